// File: rtl/reimu_life_ctrl.sv
// Player life controller: turns bullet-stage hit flags into lives, invulnerability, blink and game-over.
// Optional extra-life pickup enabled by defining REIMU_EXTRA_LIFE_EN.
module reimu_life_ctrl #(
  parameter int INIT_LIVES   = 3,
  parameter int INVULN_TICKS = 32,
  parameter int BLINK_BIT    = 2
) (
  input  logic       clk22,
  input  logic       rst,
  input  logic       start,
  input  logic       shot,
  input  logic       bonus,
  output logic [2:0] lives,
  output logic [1:0] state,
  output logic       invuln,
  output logic       blink,
  output logic       hit_pulse,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  localparam logic [2:0] LIVES_LOAD = 3'(INIT_LIVES);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_TICKS - 1);

  state_t     state_q;
  logic [7:0] invCnt_q;
  logic [2:0] lives_q;
  logic       invuln_q;
  logic       blink_q;
  logic       hitPulse_q;
  logic       gameOver_q;

  logic       bonusGain;
  logic [2:0] livesBonus_d;
  logic [2:0] livesHit_d;
  logic [7:0] invCntDec_d;

`ifdef REIMU_EXTRA_LIFE_EN
  assign bonusGain = bonus && ((state_q == ALIVE) || (state_q == INVULN));
`else
  logic unused_bonus;
  assign unused_bonus = bonus;
  assign bonusGain    = 1'b0;
`endif

  // A bonus on the same tick as a hit cancels the loss, so the net count is unchanged.
  always_comb begin
    livesBonus_d = lives_q;
    if (bonusGain && (lives_q != 3'd7))
      livesBonus_d = lives_q + 3'd1;
    livesHit_d  = bonusGain ? lives_q : (lives_q - 3'd1);
    invCntDec_d = invCnt_q - 8'd1;
  end

  always_ff @(posedge clk22) begin
    if (rst) begin
      state_q    <= IDLE;
      lives_q    <= 3'd0;
      invCnt_q   <= 8'd0;
      invuln_q   <= 1'b0;
      blink_q    <= 1'b0;
      hitPulse_q <= 1'b0;
      gameOver_q <= 1'b0;
    end else begin
      invuln_q   <= 1'b0;
      blink_q    <= 1'b0;
      hitPulse_q <= 1'b0;
      gameOver_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ALIVE;
            lives_q <= LIVES_LOAD;
          end
        end
        ALIVE: begin
          if (shot) begin
            hitPulse_q <= 1'b1;
            lives_q    <= livesHit_d;
            if (livesHit_d == 3'd0) begin
              state_q    <= DEAD;
              gameOver_q <= 1'b1;
            end else begin
              state_q  <= INVULN;
              invCnt_q <= INV_LOAD;
              invuln_q <= 1'b1;
              blink_q  <= INV_LOAD[BLINK_BIT];
            end
          end else begin
            lives_q <= livesBonus_d;
          end
        end
        INVULN: begin
          lives_q <= livesBonus_d;
          if (invCnt_q == 8'd0) begin
            state_q <= ALIVE;
          end else begin
            invCnt_q <= invCntDec_d;
            invuln_q <= 1'b1;
            blink_q  <= invCntDec_d[BLINK_BIT];
          end
        end
        DEAD: begin
          if (start) begin
            state_q <= ALIVE;
            lives_q <= LIVES_LOAD;
          end else begin
            lives_q    <= 3'd0;
            gameOver_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lives     = lives_q;
  assign state     = state_q;
  assign invuln    = invuln_q;
  assign blink     = blink_q;
  assign hit_pulse = hitPulse_q;
  assign game_over = gameOver_q;

endmodule

// File: tb/tb_reimu_life_ctrl.sv
// Self-checking bench for reimu_life_ctrl: vector table plus multi-cycle hit/invulnerability sequences.
module tb_reimu_life_ctrl;

  logic       clk22 = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       shot  = 1'b0;
  logic       bonus = 1'b0;
  logic [2:0] lives;
  logic [1:0] state;
  logic       invuln, blink, hit_pulse, game_over;

  int compared   = 0;
  int mismatched = 0;

`ifdef REIMU_EXTRA_LIFE_EN
  localparam bit EXTRA = 1'b1;
`else
  localparam bit EXTRA = 1'b0;
`endif

  reimu_life_ctrl #(.INIT_LIVES(3), .INVULN_TICKS(32), .BLINK_BIT(2)) dut (
    .clk22(clk22), .rst(rst), .start(start), .shot(shot), .bonus(bonus),
    .lives(lives), .state(state), .invuln(invuln), .blink(blink),
    .hit_pulse(hit_pulse), .game_over(game_over)
  );

  always #5 clk22 = ~clk22;

  typedef struct {
    logic       rst, start, shot, bonus;
    logic [2:0] lives;
    logic [1:0] st;
    logic       inv, blk, hit, go;
  } vec_t;

  vec_t vecs[14];

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic sh, input logic b);
    @(negedge clk22);
    rst = r; start = s; shot = sh; bonus = b;
    @(posedge clk22);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] eL, input logic [1:0] eS,
                             input logic eI, input logic eB, input logic eH, input logic eG);
    compared++;
    if ({lives, state, invuln, blink, hit_pulse, game_over} !== {eL, eS, eI, eB, eH, eG}) begin
      mismatched++;
      $display("[TB] FAIL %s: got lives=%0d state=%0d inv=%b blink=%b hit=%b go=%b, want lives=%0d state=%0d inv=%b blink=%b hit=%b go=%b",
               name, lives, state, invuln, blink, hit_pulse, game_over, eL, eS, eI, eB, eH, eG);
    end
  endtask

  initial begin
    int invTicks;
    logic [7:0] cnt;

    vecs[0]  = '{1,0,0,0, 3'd0, 2'd0, 0,0,0,0};
    vecs[1]  = '{0,0,1,0, 3'd0, 2'd0, 0,0,0,0};
    vecs[2]  = '{0,1,0,0, 3'd3, 2'd1, 0,0,0,0};
    vecs[3]  = '{0,1,0,0, 3'd3, 2'd1, 0,0,0,0};
    vecs[4]  = '{0,0,1,0, 3'd2, 2'd2, 1,1,1,0};
    vecs[5]  = '{0,0,1,0, 3'd2, 2'd2, 1,1,0,0};
    vecs[6]  = '{0,0,0,0, 3'd2, 2'd2, 1,1,0,0};
    vecs[7]  = '{0,0,0,0, 3'd2, 2'd2, 1,1,0,0};
    vecs[8]  = '{0,0,0,0, 3'd2, 2'd2, 1,0,0,0};
    vecs[9]  = '{1,0,1,0, 3'd0, 2'd0, 0,0,0,0};
    vecs[10] = '{0,1,1,0, 3'd3, 2'd1, 0,0,0,0};
    vecs[11] = '{0,0,0,1, (EXTRA ? 3'd4 : 3'd3), 2'd1, 0,0,0,0};
    vecs[12] = '{0,0,1,0, (EXTRA ? 3'd3 : 3'd2), 2'd2, 1,1,1,0};
    vecs[13] = '{1,0,0,0, 3'd0, 2'd0, 0,0,0,0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].shot, vecs[i].bonus);
      checkOutput($sformatf("vec%0d", i), vecs[i].lives, vecs[i].st,
                  vecs[i].inv, vecs[i].blk, vecs[i].hit, vecs[i].go);
    end

    // Shot held high: one hit, 32 ticks of invulnerability, then the next hit.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("hold_start", 3'd3, 2'd1, 0, 0, 0, 0);
    invTicks = 0;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(0, 0, 1, 0);
      if (invuln) invTicks++;
      if (k == 1) begin
        checkOutput("hold_hit1", 3'd2, 2'd2, 1, 1, 1, 0);
      end else if (k <= 32) begin
        cnt = 8'(32 - k);
        checkOutput($sformatf("hold_inv%0d", k), 3'd2, 2'd2, 1, cnt[2], 0, 0);
      end else if (k == 33) begin
        checkOutput("hold_expire", 3'd2, 2'd1, 0, 0, 0, 0);
        compared++;
        if (invTicks != 32) begin
          mismatched++;
          $display("[TB] FAIL inv_duration: got %0d ticks, want 32", invTicks);
        end
      end else if (k == 34) begin
        checkOutput("hold_hit2", 3'd1, 2'd2, 1, 1, 1, 0);
      end else begin
        cnt = 8'(65 - k);
        checkOutput($sformatf("hold_inv2_%0d", k), 3'd1, 2'd2, 1, cnt[2], 0, 0);
      end
    end

    // Three separated hits down to game over, then restart with a simultaneous shot.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int h = 1; h <= 3; h++) begin
      applyStimulus(0, 0, 1, 0);
      if (h < 3) begin
        checkOutput($sformatf("sep_hit%0d", h), 3'(3 - h), 2'd2, 1, 1, 1, 0);
        for (int j = 1; j <= 32; j++) begin
          applyStimulus(0, 0, 0, 0);
          if (j == 31) checkOutput($sformatf("sep_last_inv%0d", h), 3'(3 - h), 2'd2, 1, 0, 0, 0);
          if (j == 32) checkOutput($sformatf("sep_alive%0d", h), 3'(3 - h), 2'd1, 0, 0, 0, 0);
        end
      end else begin
        checkOutput("sep_dead", 3'd0, 2'd3, 0, 0, 1, 1);
      end
    end
    for (int j = 0; j < 3; j++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput($sformatf("dead_shot%0d", j), 3'd0, 2'd3, 0, 0, 0, 1);
    end
    applyStimulus(0, 1, 1, 0);
    checkOutput("dead_restart", 3'd3, 2'd1, 0, 0, 0, 0);

`ifdef REIMU_EXTRA_LIFE_EN
    // Bonus cancelling a hit at one life, then saturation at seven.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int h = 1; h <= 2; h++) begin
      applyStimulus(0, 0, 1, 0);
      for (int j = 1; j <= 32; j++) applyStimulus(0, 0, 0, 0);
    end
    checkOutput("bonus_pre", 3'd1, 2'd1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("bonus_with_hit", 3'd1, 2'd2, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int j = 0; j < 4; j++) applyStimulus(0, 0, 0, 1);
    checkOutput("bonus_to7", 3'd7, 2'd1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bonus_sat", 3'd7, 2'd1, 0, 0, 0, 0);
`else
    // Without the extra-life build, bonus never changes the life count.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("bonus_ignored_hit", 3'd2, 2'd2, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bonus_ignored_inv", 3'd2, 2'd2, 1, 1, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
